core_pattern_player: RTL and testbench

Synthesizable, parametrised stimulus player and self-checker for the `core` op/in/out handshake protocol. It replaces hand-written bench sequencing and can also run on FPGA as BIST. It reads op codes, input bytes and golden words from three asynchronous-read pattern memories and drives `core`'s op and input handshakes, optionally with pseudo-random input bubbles. It compares every `core` output against golden data and reports pass/fail, error count, first-error index and timeout.

---
 rtl/core_tb_pkg.sv | 15 +
 rtl/core_pattern_player_if.sv | 30 +++
 rtl/lfsr_gap_gen.sv | 24 ++
 rtl/core_pattern_player.sv | 233 +++++++++++++++++++++++
 tb/tb_core_pattern_player.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_tb_pkg.sv
// Shared types for core_pattern_player:
// FSM states, default load op, sentinels.
package core_tb_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_ISSUE,
    S_LOAD,
    S_DONE
  } state_t;

  localparam logic [3:0]  LOAD_OP_DEF = 4'd0;
  localparam logic [31:0] NO_ERR      = '1;
  localparam logic [15:0] LFSR_SEED   = 16'hACE1;
endpackage

// File: rtl/core_pattern_player_if.sv
// Op / input / output handshake bundle
// between the pattern player and core.
interface core_pattern_player_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 14,
  parameter int OP_W   = 4
);
  logic              o_op_valid;
  logic [OP_W-1:0]   o_op_mode;
  logic              i_op_ready;
  logic              o_in_valid;
  logic [DATA_W-1:0] o_in_data;
  logic              i_in_ready;
  logic              i_out_valid;
  logic [OUT_W-1:0]  i_out_data;

  modport master (
    output o_op_valid, o_op_mode,
    output o_in_valid, o_in_data,
    input  i_op_ready, i_in_ready,
    input  i_out_valid, i_out_data
  );

  modport slave (
    input  o_op_valid, o_op_mode,
    input  o_in_valid, o_in_data,
    output i_op_ready, i_in_ready,
    output i_out_valid, i_out_data
  );
endinterface

// File: rtl/lfsr_gap_gen.sv
// 16-bit Fibonacci LFSR bubble source;
// vetoes a cycle when the low two bits are zero.
module lfsr_gap_gen
  import core_tb_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_veto
);
  logic [15:0] lfsr;
  logic        fb;

  // taps 16,14,13,11
  assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  lfsr <= LFSR_SEED;
    else if (!i_en) lfsr <= LFSR_SEED;
    else           lfsr <= {lfsr[14:0], fb};
  end

  assign o_veto = i_en && (lfsr[1:0] == 2'b00);
endmodule

// File: rtl/core_pattern_player.sv
// Pattern-memory driven stimulus player and
// golden-data checker for the core handshakes.
module core_pattern_player
  import core_tb_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int OUT_W   = 14,
  parameter int OP_W    = 4,
  parameter int IN_AW   = 11,
  parameter int OP_AW   = 10,
  parameter int GOLD_AW = 12,
  parameter logic [OP_W-1:0] LOAD_OP = OP_W'(LOAD_OP_DEF),
  parameter int LOAD_LEN    = 2048,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [OP_AW:0]     i_op_num,
  input  logic [GOLD_AW:0]   i_gold_num,
  input  logic               i_gap_en,
  output logic [OP_AW-1:0]   o_op_addr,
  input  logic [OP_W-1:0]    i_op_rdata,
  output logic [IN_AW-1:0]   o_in_addr,
  input  logic [DATA_W-1:0]  i_in_rdata,
  output logic [GOLD_AW-1:0] o_gold_addr,
  input  logic [OUT_W-1:0]   i_gold_rdata,
  core_pattern_player_if.master hs,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic               o_timeout,
  output logic [15:0]        o_err_cnt,
  output logic [GOLD_AW:0]   o_first_err
);
  localparam int OW  = OP_AW + 1;
  localparam int GW  = GOLD_AW + 1;
  localparam int LCW = $clog2(LOAD_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [LCW-1:0] LEN  = LCW'(LOAD_LEN);
  localparam logic [TCW-1:0] TMO  = TCW'(TIMEOUT_CYC);
  localparam logic [GW-1:0]  NONE = NO_ERR[GW-1:0];

  state_t             state_q, state_d;
  logic [OW-1:0]      op_idx_q, op_idx_d;
  logic [GW-1:0]      gold_idx_q, gold_idx_d;
  logic [IN_AW-1:0]   in_idx_q, in_idx_d;
  logic [LCW-1:0]     load_cnt_q, load_cnt_d, cnt_nx;
  logic [TCW-1:0]     idle_q, idle_d;
  logic [15:0]        err_q, err_d;
  logic [GW-1:0]      first_q, first_d;
  logic               pass_q, pass_d, tmo_q, tmo_d;
  logic               done_q, done_d;
  logic               op_valid_q, op_valid_d;
  logic [OP_W-1:0]    op_mode_q, op_mode_d;
  logic               in_valid_q, in_valid_d;
  logic [DATA_W-1:0]  in_data_q, in_data_d;
  logic               busy, xfer, miss, fin, expire, veto;

  lfsr_gap_gen u_gap (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_gap_en),
    .o_veto  (veto)
  );

  assign busy = (state_q == S_WAIT_RDY) ||
                (state_q == S_ISSUE) ||
                (state_q == S_LOAD);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      op_idx_q   <= '0;
      gold_idx_q <= '0;
      in_idx_q   <= '0;
      load_cnt_q <= '0;
      idle_q     <= '0;
      err_q      <= '0;
      first_q    <= NONE;
      pass_q     <= 1'b0;
      tmo_q      <= 1'b0;
      done_q     <= 1'b0;
      op_valid_q <= 1'b0;
      op_mode_q  <= '0;
      in_valid_q <= 1'b0;
      in_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_idx_q   <= op_idx_d;
      gold_idx_q <= gold_idx_d;
      in_idx_q   <= in_idx_d;
      load_cnt_q <= load_cnt_d;
      idle_q     <= idle_d;
      err_q      <= err_d;
      first_q    <= first_d;
      pass_q     <= pass_d;
      tmo_q      <= tmo_d;
      done_q     <= done_d;
      op_valid_q <= op_valid_d;
      op_mode_q  <= op_mode_d;
      in_valid_q <= in_valid_d;
      in_data_q  <= in_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_idx_d   = op_idx_q;
    gold_idx_d = gold_idx_q;
    in_idx_d   = in_idx_q;
    load_cnt_d = load_cnt_q;
    idle_d     = idle_q;
    err_d      = err_q;
    first_d    = first_q;
    pass_d     = pass_q;
    tmo_d      = tmo_q;
    done_d     = done_q;
    op_valid_d = 1'b0;
    op_mode_d  = op_mode_q;
    in_valid_d = in_valid_q;
    in_data_d  = in_data_q;
    miss       = 1'b0;
    fin        = 1'b0;
    expire     = 1'b0;
    xfer       = in_valid_q && hs.i_in_ready;
    cnt_nx     = load_cnt_q + LCW'(xfer);

    // overflow outputs count as misses; index saturates
    if (busy && hs.i_out_valid) begin
      if (gold_idx_q < i_gold_num) begin
        gold_idx_d = gold_idx_q + GW'(1);
        miss = hs.i_out_data != i_gold_rdata;
      end else begin
        miss = 1'b1;
      end
    end
    if (miss) begin
      if (err_q != '1) err_d = err_q + 16'd1;
      if (err_q == '0) first_d = gold_idx_q;
    end
    if (busy) begin
      if (state_q == S_ISSUE || xfer || hs.i_out_valid)
        idle_d = '0;
      else
        idle_d = idle_q + TCW'(1);
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d    = S_WAIT_RDY;
          op_idx_d   = '0;
          gold_idx_d = '0;
          in_idx_d   = '0;
          load_cnt_d = '0;
          idle_d     = '0;
          err_d      = '0;
          first_d    = NONE;
          pass_d     = 1'b0;
          tmo_d      = 1'b0;
          done_d     = 1'b0;
          in_valid_d = 1'b0;
        end
      end
      S_WAIT_RDY: begin
        if (op_idx_q == i_op_num &&
            gold_idx_q == i_gold_num) begin
          fin = 1'b1;
        end else if (hs.i_op_ready &&
                     op_idx_q < i_op_num) begin
          state_d    = S_ISSUE;
          op_valid_d = 1'b1;
          op_mode_d  = i_op_rdata;
        end else if (idle_d == TMO) begin
          expire = 1'b1;
        end
      end
      S_ISSUE: begin
        op_idx_d = op_idx_q + OW'(1);
        state_d  = S_WAIT_RDY;
        if (op_mode_q == LOAD_OP) begin
          state_d    = S_LOAD;
          load_cnt_d = '0;
          if (!veto) begin
            in_valid_d = 1'b1;
            in_data_d  = i_in_rdata;
            in_idx_d   = in_idx_q + IN_AW'(1);
          end
        end
      end
      S_LOAD: begin
        load_cnt_d = cnt_nx;
        // refill only when the slot is free, so valid never drops early
        if (!in_valid_q || xfer) begin
          in_valid_d = 1'b0;
          if (!veto && cnt_nx < LEN) begin
            in_valid_d = 1'b1;
            in_data_d  = i_in_rdata;
            in_idx_d   = in_idx_q + IN_AW'(1);
          end
        end
        if (cnt_nx == LEN)
          state_d = S_WAIT_RDY;
        else if (idle_d == TMO)
          expire = 1'b1;
      end
      default: ;
    endcase

    if (fin || expire) begin
      state_d    = S_DONE;
      done_d     = 1'b1;
      tmo_d      = expire;
      pass_d     = (err_d == '0) && !expire;
      in_valid_d = 1'b0;
    end
  end

  assign o_op_addr     = op_idx_q[OP_AW-1:0];
  assign o_in_addr     = in_idx_q;
  assign o_gold_addr   = gold_idx_q[GOLD_AW-1:0];
  assign hs.o_op_valid = op_valid_q;
  assign hs.o_op_mode  = op_mode_q;
  assign hs.o_in_valid = in_valid_q;
  assign hs.o_in_data  = in_data_q;
  assign o_busy        = busy;
  assign o_done        = done_q;
  assign o_pass        = pass_q;
  assign o_timeout     = tmo_q;
  assign o_err_cnt     = err_q;
  assign o_first_err   = first_q;
endmodule

// File: tb/tb_core_pattern_player.sv
// Randomised bench for core_pattern_player with
// a behavioural core model and reference results.
module tb_core_pattern_player;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [10:0] op_num = '0;
  logic [12:0] gold_num = '0;
  logic        gap_en = 1'b0;
  logic [9:0]  op_addr;
  logic [3:0]  op_rdata;
  logic [11:0] in_addr;
  logic [7:0]  in_rdata;
  logic [11:0] gold_addr;
  logic [13:0] gold_rdata;
  logic        busy, done, pass, tmo;
  logic [15:0] err_cnt;
  logic [12:0] first_err;

  logic [3:0]  op_mem   [1024];
  logic [7:0]  in_mem   [4096];
  logic [13:0] gold_mem [4096];

  always #5 clk = ~clk;

  core_pattern_player_if #(.DATA_W(8), .OUT_W(14), .OP_W(4)) hs ();

  assign op_rdata   = op_mem[op_addr];
  assign in_rdata   = in_mem[in_addr];
  assign gold_rdata = gold_mem[gold_addr];

  core_pattern_player #(
    .IN_AW(12),
    .TIMEOUT_CYC(100)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_op_num     (op_num),
    .i_gold_num   (gold_num),
    .i_gap_en     (gap_en),
    .o_op_addr    (op_addr),
    .i_op_rdata   (op_rdata),
    .o_in_addr    (in_addr),
    .i_in_rdata   (in_rdata),
    .o_gold_addr  (gold_addr),
    .i_gold_rdata (gold_rdata),
    .hs           (hs),
    .o_busy       (busy),
    .o_done       (done),
    .o_pass       (pass),
    .o_timeout    (tmo),
    .o_err_cnt    (err_cnt),
    .o_first_err  (first_err)
  );

  int total = 0;
  int bad = 0;
  int n_out, bad_idx, emit_after, rdy_mode, rst_at, glitch_cyc;
  bit hold_op, rnd_out;
  logic [7:0] rcv [$];
  logic [3:0] ops_q [$];
  int k_out, stab_err, opw_err, c_first_op, c_done;

  task automatic set_defaults();
    n_out = 16; bad_idx = -1; emit_after = 2; rdy_mode = 0;
    rst_at = -1; glitch_cyc = -1; hold_op = 0; rnd_out = 0;
    gap_en = 1'b0;
    for (int k = 0; k < 32; k++) gold_mem[k] = 14'($urandom);
  endtask

  // behavioural core: accepts ops/bytes, emits outputs
  task automatic drive(input int budget);
    logic prev_op, prev_hold;
    logic [7:0] pdata;
    rcv.delete(); ops_q.delete();
    k_out = 0; stab_err = 0; opw_err = 0;
    c_first_op = -1; c_done = -1;
    prev_op = 0; prev_hold = 0; pdata = '0;
    hs.i_op_ready = 1'b1; hs.i_in_ready = 1'b1; hs.i_out_valid = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      start = (c == glitch_cyc);
      if (done) begin c_done = c; break; end
      if (hs.o_op_valid) begin
        if (prev_op) opw_err++;
        if (c_first_op < 0) c_first_op = c;
        ops_q.push_back(hs.o_op_mode);
      end
      prev_op = hs.o_op_valid;
      if (prev_hold && (!hs.o_in_valid || hs.o_in_data !== pdata))
        stab_err++;
      case (rdy_mode)
        0: hs.i_in_ready = 1'b1;
        1: hs.i_in_ready = ~hs.i_in_ready;
        default: hs.i_in_ready = 1'($urandom_range(0, 1));
      endcase
      prev_hold = hs.o_in_valid && !hs.i_in_ready;
      pdata = hs.o_in_data;
      if (hs.o_in_valid && hs.i_in_ready) rcv.push_back(hs.o_in_data);
      hs.i_op_ready = !(hold_op && ops_q.size() > 0);
      if (ops_q.size() >= emit_after && k_out < n_out &&
          (!rnd_out || $urandom_range(0, 1) == 1)) begin
        hs.i_out_valid = 1'b1;
        hs.i_out_data = gold_mem[k_out] ^ ((k_out == bad_idx) ? 14'h1 : 14'h0);
        k_out++;
      end else begin
        hs.i_out_valid = 1'b0;
      end
      if (rst_at >= 0 && rcv.size() == rst_at) break;
    end
    start = 1'b0;
    hs.i_out_valid = 1'b0;
  endtask

  // reference model: results from the output plan alone
  function automatic int exp_errs();
    int e = 0;
    for (int k = 0; k < n_out; k++)
      if (k >= int'(gold_num) || k == bad_idx) e++;
    return e;
  endfunction

  function automatic int exp_first();
    for (int k = 0; k < n_out; k++) begin
      if (k >= int'(gold_num)) return int'(gold_num);
      if (k == bad_idx) return k;
    end
    return 'h1FFF;
  endfunction

  function automatic int exp_bytes(input int issued);
    int n = 0;
    for (int i = 0; i < issued; i++) if (op_mem[i] == 4'd0) n += 2048;
    return n;
  endfunction

  function automatic int byte_errs();
    int e = 0;
    foreach (rcv[i]) if (rcv[i] !== in_mem[i % 4096]) e++;
    return e;
  endfunction

  function automatic int op_errs();
    int e = 0;
    foreach (ops_q[i]) if (ops_q[i] !== op_mem[i]) e++;
    return e;
  endfunction

  task automatic test_reset();
    #12;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
    total++; if (pass !== 1'b0) begin bad++; $display("FAIL rst_pass got=%b want=0", pass); end
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL rst_tmo got=%b want=0", tmo); end
    total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL rst_err got=%0d want=0", err_cnt); end
    total++; if (first_err !== 13'h1FFF) begin bad++; $display("FAIL rst_first got=%0h want=1fff", first_err); end
    total++; if (hs.o_op_valid !== 1'b0) begin bad++; $display("FAIL rst_opv got=%b want=0", hs.o_op_valid); end
    total++; if (hs.o_in_valid !== 1'b0) begin bad++; $display("FAIL rst_inv got=%b want=0", hs.o_in_valid); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    set_defaults();
    op_mem[0] = 4'd0; op_mem[1] = 4'd1; op_num = 11'd2; gold_num = 13'd16;
    drive(20000);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done got=%b want=1", done); end
    total++; if (rcv.size() != exp_bytes(2)) begin bad++; $display("FAIL basic_count got=%0d want=%0d", rcv.size(), exp_bytes(2)); end
    total++; if (byte_errs() != 0) begin bad++; $display("FAIL basic_data got=%0d bad bytes want=0", byte_errs()); end
    total++; if (ops_q.size() != 2 || op_errs() != 0) begin bad++; $display("FAIL basic_ops got=%0d ops %0d wrong want=2 ops", ops_q.size(), op_errs()); end
    total++; if (pass !== 1'b1) begin bad++; $display("FAIL basic_pass got=%b want=1", pass); end
    total++; if (err_cnt !== 16'(exp_errs())) begin bad++; $display("FAIL basic_err got=%0d want=%0d", err_cnt, exp_errs()); end
    total++; if (first_err !== 13'(exp_first())) begin bad++; $display("FAIL basic_first got=%0h want=%0h", first_err, exp_first()); end
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL basic_tmo got=%b want=0", tmo); end
    total++; if (opw_err != 0) begin bad++; $display("FAIL basic_opw got=%0d wide pulses want=0", opw_err); end
  endtask

  task automatic test_mismatch();
    set_defaults();
    op_mem[0] = 4'd1; op_num = 11'd1; gold_num = 13'd16;
    emit_after = 1; bad_idx = 5;
    drive(2000);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL mis_done got=%b want=1", done); end
    total++; if (err_cnt !== 16'(exp_errs())) begin bad++; $display("FAIL mis_err got=%0d want=%0d", err_cnt, exp_errs()); end
    total++; if (first_err !== 13'(exp_first())) begin bad++; $display("FAIL mis_first got=%0d want=%0d", first_err, exp_first()); end
    total++; if (pass !== 1'b0) begin bad++; $display("FAIL mis_pass got=%b want=0", pass); end
  endtask

  task automatic test_gaps();
    set_defaults();
    op_mem[0] = 4'd0; op_mem[1] = 4'd3; op_num = 11'd2; gold_num = 13'd16;
    gap_en = 1'b1; rdy_mode = 1;
    drive(30000);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL gap_done got=%b want=1", done); end
    total++; if (rcv.size() != exp_bytes(2)) begin bad++; $display("FAIL gap_count got=%0d want=%0d", rcv.size(), exp_bytes(2)); end
    total++; if (byte_errs() != 0) begin bad++; $display("FAIL gap_data got=%0d bad bytes want=0", byte_errs()); end
    total++; if (stab_err != 0) begin bad++; $display("FAIL gap_stable got=%0d violations want=0", stab_err); end
    total++; if (pass !== 1'b1) begin bad++; $display("FAIL gap_pass got=%b want=1", pass); end
  endtask

  task automatic test_timeout();
    set_defaults();
    op_mem[0] = 4'd1; op_mem[1] = 4'd1; op_num = 11'd2; gold_num = 13'd4;
    hold_op = 1; n_out = 0;
    drive(400);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL tmo_done got=%b want=1", done); end
    total++; if (tmo !== 1'b1) begin bad++; $display("FAIL tmo_flag got=%b want=1", tmo); end
    total++; if (pass !== 1'b0) begin bad++; $display("FAIL tmo_pass got=%b want=0", pass); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL tmo_busy got=%b want=0", busy); end
    total++; if (c_done - c_first_op < 100 || c_done - c_first_op > 102) begin bad++; $display("FAIL tmo_lat got=%0d want=100..102", c_done - c_first_op); end
    total++; if (ops_q.size() != 1) begin bad++; $display("FAIL tmo_ops got=%0d want=1", ops_q.size()); end
  endtask

  task automatic test_overflow();
    set_defaults();
    op_mem[0] = 4'd1; op_num = 11'd1; gold_num = 13'd16;
    emit_after = 1; n_out = 17;
    drive(2000);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL ovf_done got=%b want=1", done); end
    total++; if (err_cnt !== 16'(exp_errs())) begin bad++; $display("FAIL ovf_err got=%0d want=%0d", err_cnt, exp_errs()); end
    total++; if (first_err !== 13'(exp_first())) begin bad++; $display("FAIL ovf_first got=%0d want=%0d", first_err, exp_first()); end
    total++; if (pass !== 1'b0) begin bad++; $display("FAIL ovf_pass got=%b want=0", pass); end
  endtask

  task automatic test_reset_mid_load();
    set_defaults();
    op_mem[0] = 4'd0; op_mem[1] = 4'd1; op_num = 11'd2; gold_num = 13'd16;
    rst_at = 1000;
    drive(5000);
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mrst_busy got=%b want=0", busy); end
    total++; if (hs.o_in_valid !== 1'b0) begin bad++; $display("FAIL mrst_inv got=%b want=0", hs.o_in_valid); end
    total++; if (first_err !== 13'h1FFF) begin bad++; $display("FAIL mrst_first got=%0h want=1fff", first_err); end
    total++; if (in_addr !== 12'd0) begin bad++; $display("FAIL mrst_addr got=%0d want=0", in_addr); end
    @(negedge clk); rst_n = 1'b1;
    rst_at = -1;
    drive(20000);
    total++; if (rcv.size() != exp_bytes(2)) begin bad++; $display("FAIL mrst_count got=%0d want=%0d", rcv.size(), exp_bytes(2)); end
    total++; if (byte_errs() != 0) begin bad++; $display("FAIL mrst_data got=%0d bad bytes want=0", byte_errs()); end
    total++; if (pass !== 1'b1) begin bad++; $display("FAIL mrst_pass got=%b want=1", pass); end
  endtask

  task automatic test_back_to_back();
    set_defaults();
    op_mem[0] = 4'd0; op_mem[1] = 4'd0; op_mem[2] = 4'd2;
    op_num = 11'd3; gold_num = 13'd8; n_out = 8;
    emit_after = 1; rnd_out = 1; rdy_mode = 2; gap_en = 1'b1;
    glitch_cyc = 500;
    drive(40000);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b want=1", done); end
    total++; if (rcv.size() != exp_bytes(3)) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", rcv.size(), exp_bytes(3)); end
    total++; if (byte_errs() != 0) begin bad++; $display("FAIL b2b_data got=%0d bad bytes want=0", byte_errs()); end
    total++; if (ops_q.size() != 3 || op_errs() != 0) begin bad++; $display("FAIL b2b_ops got=%0d ops %0d wrong want=3 ops", ops_q.size(), op_errs()); end
    total++; if (stab_err != 0) begin bad++; $display("FAIL b2b_stable got=%0d violations want=0", stab_err); end
    total++; if (pass !== 1'b1 || err_cnt !== 16'(exp_errs())) begin bad++; $display("FAIL b2b_pass got=%b err=%0d want=1 err=%0d", pass, err_cnt, exp_errs()); end
  endtask

  initial begin
    hs.i_op_ready = 1'b0; hs.i_in_ready = 1'b0;
    hs.i_out_valid = 1'b0; hs.i_out_data = '0;
    for (int i = 0; i < 1024; i++) op_mem[i] = 4'd1;
    for (int i = 0; i < 4096; i++) in_mem[i] = 8'($urandom);
    for (int i = 0; i < 4096; i++) gold_mem[i] = '0;
    test_reset();
    test_basic();
    test_mismatch();
    test_gaps();
    test_timeout();
    test_overflow();
    test_reset_mid_load();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
